// File: rtl/operand_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage_pkg
// Shared constants for the CO224 decode/operand-fetch stage and the ALU behind
// it: opcodes, ALU select encodings, default widths and instruction field
// positions. No ports.
// -----------------------------------------------------------------------------
package operand_fetch_stage_pkg;

   localparam int OFS_DATA_W = 8;
   localparam int OFS_REG_N  = 8;
   localparam int OFS_ADDR_W = 3;

   // Opcodes, instr[31:24]
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;

   // ALU select, shared with the ALU
   typedef enum logic [2:0] {
      ALU_FWD = 3'd0,
      ALU_ADD = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3
   } alu_sel_e;

   // Instruction field bit positions
   localparam int OPC_HI  = 31;
   localparam int OPC_LO  = 24;
   localparam int DST_HI  = 23;
   localparam int DST_LO  = 16;
   localparam int SRC1_HI = 15;
   localparam int SRC1_LO = 8;
   localparam int SRC2_HI = 7;
   localparam int SRC2_LO = 0;

   // A register field is legal only when the bits above the address are zero.
   function automatic logic field_ok(input logic [7:0] f);
      return (f >> OFS_ADDR_W) == 8'd0;
   endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage_if
// Bundles the instruction handshake, the write-back bus and the ALU-side
// output bundle of the operand fetch stage.
//   slave  : the stage (consumes instr/wb/out_ready, drives in_ready + bundle)
//   master : the environment around the stage (issuer, write-back, ALU)
// -----------------------------------------------------------------------------
interface operand_fetch_stage_if
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_W = OFS_DATA_W,
   parameter int ADDR_W = OFS_ADDR_W
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [2:0]        alu_sel;
   logic [ADDR_W-1:0] dest;
   logic              wr_en;
   logic              illegal;

   modport slave (
      input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, op_a, op_b, alu_sel, dest, wr_en, illegal
   );

   modport master (
      output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, op_a, op_b, alu_sel, dest, wr_en, illegal
   );
endinterface

// File: rtl/operand_fetch_stage_reg_file.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage_reg_file
// REG_N x DATA_W register file, two asynchronous read ports, one synchronous
// write port, asynchronous active-high reset clearing every entry.
//   i_clk, i_rst            clock / async reset
//   i_we, i_waddr, i_wdata  write port
//   i_raddr_a / o_rdata_a   read port A
//   i_raddr_b / o_rdata_b   read port B
// -----------------------------------------------------------------------------
module operand_fetch_stage_reg_file
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_W = OFS_DATA_W,
   parameter int REG_N  = OFS_REG_N,
   parameter int ADDR_W = OFS_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);
   logic [DATA_W-1:0] r_mem [REG_N];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
// Decodes a 32-bit instruction, reads its operands from the register file
// (with same-cycle write-back bypass) and registers the ALU bundle in a
// valid/ready pipeline register.
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset (clears regfile and bundle)
//   bus    operand_fetch_stage_if.slave: in_valid/in_ready/instr, wb_*,
//          out_valid/out_ready, op_a, op_b, alu_sel, dest, wr_en, illegal
// -----------------------------------------------------------------------------
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_W = OFS_DATA_W,
   parameter int REG_N  = OFS_REG_N,
   parameter int ADDR_W = OFS_ADDR_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   operand_fetch_stage_if.slave  bus
);
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   logic [7:0]        w_opc, w_dst_f, w_src1_f, w_src2_f;
   logic [DATA_W-1:0] w_rf_a, w_rf_b, w_op1, w_op2;
   logic [DATA_W-1:0] w_a, w_b;
   alu_sel_e          w_sel;
   logic              w_we, w_ill, w_fire;

   logic              r_valid;
   logic [DATA_W-1:0] r_op_a, r_op_b;
   logic [2:0]        r_sel;
   logic [ADDR_W-1:0] r_dest;
   logic              r_wr_en, r_illegal;

   assign w_opc    = bus.instr[OPC_HI:OPC_LO];
   assign w_dst_f  = bus.instr[DST_HI:DST_LO];
   assign w_src1_f = bus.instr[SRC1_HI:SRC1_LO];
   assign w_src2_f = bus.instr[SRC2_HI:SRC2_LO];

   operand_fetch_stage_reg_file #(
      .DATA_W (DATA_W),
      .REG_N  (REG_N),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (bus.wb_en),
      .i_waddr   (bus.wb_addr),
      .i_wdata   (bus.wb_data),
      .i_raddr_a (w_src1_f[ADDR_W-1:0]),
      .o_rdata_a (w_rf_a),
      .i_raddr_b (w_src2_f[ADDR_W-1:0]),
      .o_rdata_b (w_rf_b)
   );

   // A write landing this edge would otherwise be missed by the read.
   assign w_op1 = (bus.wb_en && bus.wb_addr == w_src1_f[ADDR_W-1:0]) ? bus.wb_data : w_rf_a;
   assign w_op2 = (bus.wb_en && bus.wb_addr == w_src2_f[ADDR_W-1:0]) ? bus.wb_data : w_rf_b;

   // Only fields an opcode actually uses are checked for stray upper bits
   // (LOADI: dest; MOV: dest, src2; binary ops: all three).
   always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_sel = ALU_FWD;
      w_we  = 1'b0;
      w_ill = 1'b0;
      case (w_opc)
         OP_LOADI: begin
            w_ill = !field_ok(w_dst_f);
            w_a   = w_src2_f[DATA_W-1:0];
            w_we  = 1'b1;
         end
         OP_MOV: begin
            w_ill = !(field_ok(w_dst_f) && field_ok(w_src2_f));
            w_a   = w_op2;
            w_we  = 1'b1;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ill = !(field_ok(w_dst_f) && field_ok(w_src1_f) && field_ok(w_src2_f));
            w_a   = w_op1;
            w_b   = (w_opc == OP_SUB) ? (~w_op2 + ONE) : w_op2;
            w_we  = 1'b1;
            case (w_opc)
               OP_AND:  w_sel = ALU_AND;
               OP_OR:   w_sel = ALU_OR;
               default: w_sel = ALU_ADD;
            endcase
         end
         default: w_ill = 1'b1;
      endcase
      if (w_ill) begin
         w_a   = '0;
         w_b   = '0;
         w_sel = ALU_FWD;
         w_we  = 1'b0;
      end
   end

   assign bus.in_ready = !r_valid || bus.out_ready;
   assign w_fire       = bus.in_valid && bus.in_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid   <= 1'b0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_sel     <= '0;
         r_dest    <= '0;
         r_wr_en   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_fire) begin
         r_valid   <= 1'b1;
         r_op_a    <= w_a;
         r_op_b    <= w_b;
         r_sel     <= w_sel;
         r_dest    <= w_ill ? '0 : w_dst_f[ADDR_W-1:0];
         r_wr_en   <= w_we;
         r_illegal <= w_ill;
      end else if (bus.out_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.op_a      = r_op_a;
   assign bus.op_b      = r_op_b;
   assign bus.alu_sel   = r_sel;
   assign bus.dest      = r_dest;
   assign bus.wr_en     = r_wr_en;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
// Directed scenarios plus a randomized run against a transaction-level model:
// an 8-entry array for the register file and a one-deep held-bundle model.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;
   import operand_fetch_stage_pkg::*;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sel;
      logic [2:0] dst;
      logic       we;
      logic       ill;
   } bund_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_fetch_stage_if bus ();

   operand_fetch_stage dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int    errs = 0;
   int    checks = 0;
   int    n_acc = 0;
   int    n_del = 0;
   logic [7:0] mrf [8];
   logic  mv;
   bund_t mb;

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s2);
      return {op, d, s1, s2};
   endfunction

   function automatic bund_t dut_b();
      return '{a: bus.op_a, b: bus.op_b, sel: bus.alu_sel, dst: bus.dest,
               we: bus.wr_en, ill: bus.illegal};
   endfunction

   // Reference decode: what the ALU should receive for this instruction given
   // the architectural register contents and any write landing this cycle.
   function automatic bund_t ref_decode(input logic [31:0] ins, input logic wbe,
                                        input logic [2:0] wba, input logic [7:0] wbd);
      bund_t r;
      int opc, d, s1, s2, v1, v2;
      logic bad;
      opc = int'(ins[31:24]); d = int'(ins[23:16]);
      s1  = int'(ins[15:8]);  s2 = int'(ins[7:0]);
      v1  = (wbe && int'(wba) == s1 % 8) ? int'(wbd) : int'(mrf[s1 % 8]);
      v2  = (wbe && int'(wba) == s2 % 8) ? int'(wbd) : int'(mrf[s2 % 8]);
      r   = '0;
      r.dst = 3'(d % 8);
      r.we  = 1'b1;
      bad   = 1'b0;
      case (opc)
         0: begin bad = d > 7;                     r.a = 8'(s2); end
         1: begin bad = d > 7 || s2 > 7;           r.a = 8'(v2); end
         2: begin bad = d > 7 || s1 > 7 || s2 > 7; r.a = 8'(v1); r.b = 8'(v2); r.sel = 3'd1; end
         3: begin bad = d > 7 || s1 > 7 || s2 > 7; r.a = 8'(v1); r.b = 8'((256 - v2) % 256); r.sel = 3'd1; end
         4: begin bad = d > 7 || s1 > 7 || s2 > 7; r.a = 8'(v1); r.b = 8'(v2); r.sel = 3'd2; end
         5: begin bad = d > 7 || s1 > 7 || s2 > 7; r.a = 8'(v1); r.b = 8'(v2); r.sel = 3'd3; end
         default: bad = 1'b1;
      endcase
      if (bad) r = '{a: 8'h00, b: 8'h00, sel: 3'd0, dst: 3'd0, we: 1'b0, ill: 1'b1};
      return r;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                        input logic we, input logic [2:0] wa, input logic [7:0] wd);
      bus.in_valid  = v;
      bus.instr     = ins;
      bus.out_ready = ordy;
      bus.wb_en     = we;
      bus.wb_addr   = wa;
      bus.wb_data   = wd;
      #1;
   endtask

   // One clock edge; advances the model alongside the DUT.
   task automatic tick();
      logic  fire;
      bund_t nb;
      fire = bus.in_valid && (!mv || bus.out_ready);
      nb   = ref_decode(bus.instr, bus.wb_en, bus.wb_addr, bus.wb_data);
      @(posedge clk);
      if (mv && bus.out_ready) n_del++;
      if (fire) begin mv = 1'b1; mb = nb; n_acc++; end
      else if (bus.out_ready) mv = 1'b0;
      if (bus.wb_en) mrf[bus.wb_addr] = bus.wb_data;
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
      mv = 1'b0; mb = '0; n_acc = 0; n_del = 0;
   endtask

   task automatic test_reset();
      bund_t exp;
      model_reset();
      rst = 1'b1;
      drive(0, 32'h0, 1, 0, 3'd0, 8'h00);
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || dut_b() !== bund_t'(0))
         begin errs++; $display("FAIL reset_outputs: got v=%b %h want v=0 0", bus.out_valid, dut_b()); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         begin errs++; $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid); end
      drive(1, mk(OP_LOADI, 8'd1, 8'd0, 8'h07), 1, 0, 3'd0, 8'h00);
      tick();
      exp = '{a: 8'h07, b: 8'h00, sel: 3'd0, dst: 3'd1, we: 1'b1, ill: 1'b0};
      checks++;
      if (bus.out_valid !== 1'b1 || dut_b() !== exp)
         begin errs++; $display("FAIL loadi: got v=%b %h want v=1 %h", bus.out_valid, dut_b(), exp); end
   endtask

   task automatic test_alu_ops();
      logic [7:0] ops  [4] = '{OP_ADD, OP_AND, OP_OR, OP_SUB};
      logic [2:0] sels [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
      logic [7:0] bs   [4] = '{8'h03, 8'h03, 8'h03, 8'hFD};
      bund_t exp;
      drive(0, 32'h0, 1, 1, 3'd1, 8'h07); tick();
      drive(0, 32'h0, 1, 1, 3'd2, 8'h03); tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, mk(ops[i], 8'd3, 8'd1, 8'd2), 1, 0, 3'd0, 8'h00);
         tick();
         exp = '{a: 8'h07, b: bs[i], sel: sels[i], dst: 3'd3, we: 1'b1, ill: 1'b0};
         checks++;
         if (bus.out_valid !== 1'b1 || dut_b() !== exp)
            begin errs++; $display("FAIL alu_op%0d: got v=%b %h want v=1 %h", i, bus.out_valid, dut_b(), exp); end
      end
   endtask

   task automatic test_bypass();
      bund_t exp;
      drive(1, mk(OP_ADD, 8'd4, 8'd2, 8'd2), 1, 1, 3'd2, 8'h55);
      tick();
      exp = '{a: 8'h55, b: 8'h55, sel: 3'd1, dst: 3'd4, we: 1'b1, ill: 1'b0};
      checks++;
      if (bus.out_valid !== 1'b1 || dut_b() !== exp)
         begin errs++; $display("FAIL bypass: got v=%b %h want v=1 %h", bus.out_valid, dut_b(), exp); end
      drive(1, mk(OP_MOV, 8'd5, 8'd0, 8'd2), 1, 0, 3'd0, 8'h00);
      tick();
      exp = '{a: 8'h55, b: 8'h00, sel: 3'd0, dst: 3'd5, we: 1'b1, ill: 1'b0};
      checks++;
      if (bus.out_valid !== 1'b1 || dut_b() !== exp)
         begin errs++; $display("FAIL bypass_array: got v=%b %h want v=1 %h", bus.out_valid, dut_b(), exp); end
   endtask

   task automatic test_backpressure();
      bund_t ea, eb;
      ea = '{a: 8'hA5, b: 8'h00, sel: 3'd0, dst: 3'd6, we: 1'b1, ill: 1'b0};
      eb = '{a: 8'h3C, b: 8'h00, sel: 3'd0, dst: 3'd7, we: 1'b1, ill: 1'b0};
      drive(1, mk(OP_LOADI, 8'd6, 8'd0, 8'hA5), 1, 0, 3'd0, 8'h00);
      tick();
      drive(1, mk(OP_LOADI, 8'd7, 8'd0, 8'h3C), 0, 0, 3'd0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.in_ready !== 1'b0)
            begin errs++; $display("FAIL stall_ready%0d: got %b want 0", i, bus.in_ready); end
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || dut_b() !== ea)
            begin errs++; $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", i, bus.out_valid, dut_b(), ea); end
      end
      drive(1, mk(OP_LOADI, 8'd7, 8'd0, 8'h3C), 1, 0, 3'd0, 8'h00);
      checks++;
      if (bus.in_ready !== 1'b1)
         begin errs++; $display("FAIL release_ready: got %b want 1", bus.in_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || dut_b() !== eb)
         begin errs++; $display("FAIL release_bundle: got v=%b %h want v=1 %h", bus.out_valid, dut_b(), eb); end
      drive(0, 32'h0, 1, 0, 3'd0, 8'h00);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0)
         begin errs++; $display("FAIL drain: got out_valid=%b want 0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      logic [31:0] ins [2];
      bund_t exp;
      ins[0] = mk(8'h09, 8'd1, 8'd1, 8'd2);
      ins[1] = mk(OP_ADD, 8'd1, 8'h08, 8'd2);
      exp = '{a: 8'h00, b: 8'h00, sel: 3'd0, dst: 3'd0, we: 1'b0, ill: 1'b1};
      for (int i = 0; i < 2; i++) begin
         drive(1, ins[i], 1, 0, 3'd0, 8'h00);
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || dut_b() !== exp)
            begin errs++; $display("FAIL illegal%0d: got v=%b %h want v=1 %h", i, bus.out_valid, dut_b(), exp); end
      end
   endtask

   task automatic test_async_reset();
      bund_t exp;
      drive(1, mk(OP_LOADI, 8'd2, 8'd0, 8'hEE), 1, 0, 3'd0, 8'h00);
      tick();
      drive(0, 32'h0, 0, 0, 3'd0, 8'h00);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1)
         begin errs++; $display("FAIL pre_reset_hold: got out_valid=%b want 1", bus.out_valid); end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, dut_b()} !== 25'd0)
         begin errs++; $display("FAIL async_reset: got v=%b %h want v=0 0", bus.out_valid, dut_b()); end
      model_reset();
      @(negedge clk); rst = 1'b0;
      drive(1, mk(OP_MOV, 8'd3, 8'd0, 8'd1), 1, 0, 3'd0, 8'h00);
      tick();
      exp = '{a: 8'h00, b: 8'h00, sel: 3'd0, dst: 3'd3, we: 1'b1, ill: 1'b0};
      checks++;
      if (bus.out_valid !== 1'b1 || dut_b() !== exp)
         begin errs++; $display("FAIL mov_after_reset: got v=%b %h want v=1 %h", bus.out_valid, dut_b(), exp); end
   endtask

   task automatic test_random();
      logic [7:0] op, d, s1, s2;
      logic       iv, ordy, wbe;
      int         k;
      for (int i = 0; i < 400; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
         d  = 8'($urandom_range(0, 7));
         s1 = 8'($urandom_range(0, 7));
         s2 = (op == OP_LOADI) ? 8'($urandom) : 8'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, 2);
            if (k == 0) d = d | 8'(8 << $urandom_range(0, 4));
            else if (k == 1 && op != OP_MOV) s1 = s1 | 8'(8 << $urandom_range(0, 4));
            else if (k == 2 && op != OP_LOADI) s2 = s2 | 8'(8 << $urandom_range(0, 4));
         end
         iv   = 1'($urandom_range(0, 3) != 0);
         ordy = 1'($urandom_range(0, 3) != 0);
         wbe  = 1'($urandom_range(0, 1));
         drive(iv, mk(op, d, s1, s2), ordy, wbe, 3'($urandom_range(0, 7)), 8'($urandom));
         checks++;
         if (bus.in_ready !== (!mv || ordy))
            begin errs++; $display("FAIL rnd_ready@%0d: got %b want %b", i, bus.in_ready, (!mv || ordy)); end
         tick();
         checks++;
         if (bus.out_valid !== mv || (mv && dut_b() !== mb))
            begin errs++; $display("FAIL rnd_bundle@%0d: got v=%b %h want v=%b %h", i, bus.out_valid, dut_b(), mv, mb); end
      end
      drive(0, 32'h0, 1, 0, 3'd0, 8'h00);
      tick();
      checks++;
      if (n_acc !== n_del || bus.out_valid !== 1'b0)
         begin errs++; $display("FAIL rnd_count: got delivered=%0d want accepted=%0d", n_del, n_acc); end
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_bypass();
      test_backpressure();
      test_illegal();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the 8-bit ALU in the CO224 processor datapath.
- Accepts a 32-bit instruction word and decodes it.
- Reads source operands from an internal 8x8 register file, with same-cycle write-back bypass.
- Registers {operand A, operand B, ALU select, destination, write enable} into a valid/ready pipeline register that feeds the ALU.

Parameters:
- DATA_W, 8, register/operand width
- REG_N, 8, number of architectural registers
- ADDR_W, 3, register address width (log2 REG_N)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction word present
- in_ready  out  1  stage can accept instruction this cycle
- instr  in  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2 or immediate
- wb_en  in  1  write-back strobe from ALU result path
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  ALU bundle valid
- out_ready  in  1  ALU side accepts bundle
- op_a  out  DATA_W  ALU dataA
- op_b  out  DATA_W  ALU dataB
- alu_sel  out  3  ALU select: 0 FORWARD, 1 ADD, 2 AND, 3 OR
- dest  out  ADDR_W  destination register for result
- wr_en  out  1  result must be written back
- illegal  out  1  registered instruction was illegal

Behaviour:
- Reset, asynchronous and active-high:
  - All register-file entries = 0.
  - out_valid, op_a, op_b, alu_sel, dest, wr_en and illegal = 0.
  - in_ready = 1 once reset deasserts.
- Reset mid-operation discards any held bundle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Fire = in_valid && in_ready; the bundle is loaded at the next rising edge.
  - out_valid rises the cycle after fire.
  - out_valid clears at an edge where out_ready=1 and there is no new fire.
  - Back-to-back fires sustain 1 instruction/cycle.
- Holding: while out_valid && !out_ready, all outputs hold stable, in_ready=0, and instr is ignored.
- Latency: exactly 1 cycle from fire to out_valid.
- Decode (opcode):
  - 0x00 LOADI: op_a = instr[7:0], op_b = 0, sel 0, wr_en 1.
  - 0x01 MOV: op_a = R[src2], op_b = 0, sel 0, wr_en 1.
  - 0x02 ADD: op_a = R[src1], op_b = R[src2], sel 1, wr_en 1.
  - 0x03 SUB: op_a = R[src1], op_b = (~R[src2] + 1) mod 2^8, sel 1, wr_en 1.
  - 0x04 AND: sel 2.
  - 0x05 OR: sel 3.
  - For AND and OR, operands are as for ADD, with wr_en 1.
- Register fields: fields use bits [2:0]; bits [7:3] must be zero.
- Illegal instructions:
  - Triggered by any other opcode, or by nonzero upper register-field bits. For LOADI, only the dest field is checked.
  - The bundle is emitted with illegal=1, wr_en=0, sel 0, op_a=op_b=0.
  - Handshake is unchanged.
- Register file:
  - Two asynchronous read ports.
  - Write on rising edge when wb_en=1.
  - wb_en is honoured every cycle, independent of handshake or stall.
- Bypass: if wb_en && wb_addr equals a source being read in the fire cycle, that source uses wb_data, not the stale array value. SUB negation applies after bypass.
- Hazards: no interlock beyond same-cycle bypass. The issuer spaces dependent instructions.
- Arithmetic: all values are 8-bit, and overflow wraps silently.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LOADI..OP_OR)
  - ALU select constants (ALU_FWD=0, ALU_ADD=1, ALU_AND=2, ALU_OR=3)
  - DATA_W/ADDR_W defaults
  - instruction field bit positions
- The ALU consumes the same select constants from this package.
- Sub-module reg_file:
  - REG_N x DATA_W, 2R1W.
  - Asynchronous read, synchronous write.
  - Async active-high reset to 0.
- Decode, bypass muxing and the pipeline register stay in operand_fetch_stage.

Test Plan:
1. Reset with no instructions -> out_valid=0, in_ready=1. Then LOADI r1 ← 0x07 with out_ready=1 -> next cycle op_a=0x07, op_b=0, alu_sel=0, dest=1, wr_en=1.
2. Preload r1=0x07 and r2=0x03 via wb. Then ADD r3,r1,r2 -> op_a=0x07, op_b=0x03, sel=1. AND -> sel=2. OR -> sel=3. SUB r3,r1,r2 -> op_b=0xFD.
3. Bypass: ADD r4,r2,r2 fires in the same cycle as wb_en=1, wb_addr=2, wb_data=0x55 (r2 was 0x03) -> op_a=op_b=0x55. Next instruction reading r2 sees 0x55 from the array.
4. Backpressure:
   - Hold out_ready=0 after one fire, then present a second instruction.
   - Required: in_ready=0 and outputs frozen for 3 cycles.
   - Raise out_ready: the second instruction fires, and its bundle appears one cycle later.
   - No instruction is lost or duplicated.
5. Illegal: opcode 0x09, and separately ADD with src1 field 0x08 -> illegal=1, wr_en=0, sel=0, op_a=op_b=0, out_valid=1.
6. Async reset asserted mid-stall with out_valid=1 -> out_valid and all outputs drop to 0 immediately, without waiting for clk. A subsequent MOV from r1 returns 0.
